// File: rtl/axis_seq_pkg.sv
// Shared types and default widths for the AXI4-Stream packet sequencer.
// The optional watchdog is enabled by defining AXIS_SEQ_WATCHDOG_EN.
package axis_seq_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int GAP_W_DEF = 16;
    localparam int TMO_W_DEF = 20;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        ACTIVE = 3'd2,
        GAP    = 3'd3,
        FINISH = 3'd4
    } seq_state_t;

endpackage

// File: rtl/axis_seq_timer.sv
// Loadable down-counter with a zero flag. Load wins over decrement, and the
// count saturates at zero so a stalled consumer never sees it wrap.
module axis_seq_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Count register: load has priority, otherwise decrement down to zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/axis_packet_sequencer.sv
// Run-level controller for the AXI4-Stream packet master: issues start pulses,
// counts TLAST beats, inserts an idle gap between packets and reports status.
// Optional watchdog abort of a stalled packet: define AXIS_SEQ_WATCHDOG_EN.
module axis_packet_sequencer
    import axis_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF,
    parameter int TMO_W = TMO_W_DEF
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             run,
    input  logic             stop,
    input  logic [CNT_W-1:0] cfg_num_packets,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [TMO_W-1:0] cfg_timeout,
    output logic             seq_busy,
    output logic             seq_done,
    output logic [CNT_W-1:0] pkt_count,
    output logic             wd_timeout,
    output logic             m_start,
    input  logic             m_busy,
    input  logic             m_tvalid,
    input  logic             m_tready,
    input  logic             m_tlast
);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;

    logic [CNT_W-1:0] r_num;
    logic [GAP_W-1:0] r_gap;
    logic [CNT_W-1:0] r_pkt_count;
    logic             r_stop_pending;

    logic             w_run_accept;
    logic             w_last_fire;
    logic [CNT_W-1:0] w_pkt_inc;
    logic             w_pkt_final;
    logic             w_count_en;
    logic             w_gap_load;
    logic             w_gap_zero;
    logic [GAP_W-1:0] w_gap_cnt_unused;
    logic             w_wd_expire;

    assign w_run_accept = (r_state == IDLE) && run;
    assign w_last_fire  = m_tvalid && m_tready && m_tlast;
    assign w_pkt_inc    = r_pkt_count + 1'b1;
    assign w_pkt_final  = (r_num != '0) && (w_pkt_inc == r_num);
    assign pkt_count    = r_pkt_count;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode; m_start is combinational from the state
    // register so it drops the moment ARESET forces IDLE.
    // NOTE: every output gets a default first, so no path leaves a latch.
    always_comb begin
        w_state_nxt = r_state;
        m_start     = 1'b0;
        seq_busy    = 1'b1;
        seq_done    = 1'b0;
        w_count_en  = 1'b0;
        w_gap_load  = 1'b0;
        case (r_state)
            IDLE: begin
                seq_busy = 1'b0;
                if (run) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!m_busy) begin
                    m_start     = 1'b1;
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_last_fire) begin
                    w_count_en = 1'b1;
                    if (w_pkt_final || r_stop_pending || stop) begin
                        w_state_nxt = FINISH;
                    end else if (r_gap == '0) begin
                        w_state_nxt = ISSUE;
                    end else begin
                        w_gap_load  = 1'b1;
                        w_state_nxt = GAP;
                    end
                end else if (w_wd_expire) begin
                    w_state_nxt = FINISH;
                end
            end
            GAP: begin
                if (stop) begin
                    w_state_nxt = FINISH;
                end else if (w_gap_zero) begin
                    w_state_nxt = ISSUE;
                end
            end
            FINISH: begin
                seq_done    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Shadow copy of the run configuration, captured only when a run starts.
    // NOTE: shadow registers are reset even though a run always reloads them,
    // so no X can reach the finish comparison after power-up.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_num <= '0;
            r_gap <= '0;
        end else if (w_run_accept) begin
            r_num <= cfg_num_packets;
            r_gap <= cfg_gap;
        end
    end

    // Completed-packet counter: cleared at run start, held after run end.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_pkt_count <= '0;
        end else if (w_run_accept) begin
            r_pkt_count <= '0;
        end else if (w_count_en) begin
            r_pkt_count <= w_pkt_inc;
        end
    end

    // Graceful stop request: remembered until the run returns to IDLE.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_stop_pending <= 1'b0;
        end else if ((r_state == IDLE) || (w_state_nxt == IDLE)) begin
            r_stop_pending <= 1'b0;
        end else if (stop) begin
            r_stop_pending <= 1'b1;
        end
    end

    axis_seq_timer #(
        .W (GAP_W)
    ) u_gap_timer (
        .i_clk      (ACLK),
        .i_rst      (ARESET),
        .i_load     (w_gap_load),
        .i_load_val (r_gap - 1'b1),
        .i_dec      (r_state == GAP),
        .o_count    (w_gap_cnt_unused),
        .o_zero     (w_gap_zero)
    );

`ifdef AXIS_SEQ_WATCHDOG_EN
    logic [TMO_W-1:0] r_tmo;
    logic             r_wd_timeout;
    logic             w_beat;
    logic             w_wd_load;
    logic             w_wd_zero;
    logic [TMO_W-1:0] w_wd_cnt_unused;

    // The watchdog restarts when the packet is issued and on every beat;
    // loading timeout-1 makes it expire after exactly timeout idle cycles.
    assign w_beat      = m_tvalid && m_tready;
    assign w_wd_load   = ((r_state == ISSUE) && !m_busy) ||
                         ((r_state == ACTIVE) && w_beat);
    assign w_wd_expire = (r_tmo != '0) && w_wd_zero && !w_beat;
    assign wd_timeout  = r_wd_timeout;

    axis_seq_timer #(
        .W (TMO_W)
    ) u_wd_timer (
        .i_clk      (ACLK),
        .i_rst      (ARESET),
        .i_load     (w_wd_load),
        .i_load_val (r_tmo - 1'b1),
        .i_dec      (r_state == ACTIVE),
        .o_count    (w_wd_cnt_unused),
        .o_zero     (w_wd_zero)
    );

    // Shadow timeout, captured at run start.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_tmo <= '0;
        end else if (w_run_accept) begin
            r_tmo <= cfg_timeout;
        end
    end

    // Sticky timeout flag, cleared only by the next accepted run.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wd_timeout <= 1'b0;
        end else if (w_run_accept) begin
            r_wd_timeout <= 1'b0;
        end else if ((r_state == ACTIVE) && w_wd_expire) begin
            r_wd_timeout <= 1'b1;
        end
    end
`else
    logic w_unused_tmo;

    assign w_wd_expire  = 1'b0;
    assign wd_timeout   = 1'b0;
    assign w_unused_tmo = ^cfg_timeout;
`endif

endmodule

// File: tb/tb_axis_packet_sequencer.sv
// Self-checking bench for axis_packet_sequencer. A small master model answers
// m_start with fixed-length packets; a timestamp-based reference model predicts
// every output each cycle, and directed tests pin the key latencies literally.
module tb_axis_packet_sequencer;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b0;
    logic        run = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] cfg_num_packets = '0;
    logic [15:0] cfg_gap = '0;
    logic [19:0] cfg_timeout = '0;
    logic        seq_busy;
    logic        seq_done;
    logic [15:0] pkt_count;
    logic        wd_timeout;
    logic        m_start;
    logic        m_busy = 1'b0;
    logic        m_tvalid = 1'b0;
    logic        m_tready = 1'b1;
    logic        m_tlast = 1'b0;

    axis_packet_sequencer dut (
        .ACLK            (ACLK),
        .ARESET          (ARESET),
        .run             (run),
        .stop            (stop),
        .cfg_num_packets (cfg_num_packets),
        .cfg_gap         (cfg_gap),
        .cfg_timeout     (cfg_timeout),
        .seq_busy        (seq_busy),
        .seq_done        (seq_done),
        .pkt_count       (pkt_count),
        .wd_timeout      (wd_timeout),
        .m_start         (m_start),
        .m_busy          (m_busy),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_tlast         (m_tlast)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Event timestamps recorded by the compare process.
    int starts[$];
    int fires[$];
    int dones[$];

    // Values seen at the last negedge, consumed by the master model.
    logic samp_start = 1'b0;
    logic samp_beat  = 1'b0;
    logic samp_fire  = 1'b0;

    // Master model state.
    bit bfm_active = 1'b0;
    int bfm_idx = 0;
    int bfm_len = 16;
    int force_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ev(input int which, input int i);
        if (which == 0) return (i < starts.size()) ? starts[i] : -1000;
        if (which == 1) return (i < fires.size()) ? fires[i] : -1000;
        return (i < dones.size()) ? dones[i] : -1000;
    endfunction

    // Reference model: a run is a sequence of timestamps. A packet may start
    // from start_at onward when the master is free; its last beat schedules
    // either run end (next cycle) or the next start after gap+1 cycles.
    bit          mr_run = 1'b0;
    bit          mr_fin = 1'b0;
    bit          mr_inflight = 1'b0;
    bit          mr_stop = 1'b0;
    bit          mr_wd = 1'b0;
    logic [15:0] mr_num = '0;
    logic [15:0] mr_count = '0;
    int          mr_gap = 0;
    int          mr_tmo = 0;
    int          mr_start_at = 0;
    int          mr_done_at = 0;
    int          mr_active_from = 0;
    int          mr_wd_ref = 0;

    always @(negedge ACLK) begin
        bit beat, fire, exp_start, exp_done, in_gap, active;
        if (ARESET) begin
            mr_run = 0; mr_fin = 0; mr_inflight = 0; mr_stop = 0; mr_wd = 0;
            mr_count = '0;
            samp_start = 0; samp_beat = 0; samp_fire = 0;
        end else begin
            beat      = m_tvalid && m_tready;
            fire      = beat && m_tlast;
            exp_start = mr_run && !mr_fin && !mr_inflight && (cyc >= mr_start_at) && !m_busy;
            exp_done  = mr_run && mr_fin && (cyc == mr_done_at);
            check("m_start", m_start, exp_start);
            check("seq_busy", seq_busy, mr_run);
            check("seq_done", seq_done, exp_done);
            check("pkt_count", pkt_count, mr_count);
            check("wd_timeout", wd_timeout, mr_wd);
            if (m_start) starts.push_back(cyc);
            if (fire) fires.push_back(cyc);
            if (seq_done) dones.push_back(cyc);
            samp_start = m_start; samp_beat = beat; samp_fire = fire;

            if (!mr_run) begin
                if (run) begin
                    mr_run = 1; mr_fin = 0; mr_inflight = 0; mr_stop = 0; mr_wd = 0;
                    mr_count = '0;
                    mr_num = cfg_num_packets; mr_gap = cfg_gap; mr_tmo = cfg_timeout;
                    mr_start_at = cyc + 1;
                end
            end else if (exp_done) begin
                mr_run = 0; mr_stop = 0;
            end else if (!mr_fin) begin
                in_gap = !mr_inflight && (cyc < mr_start_at);
                active = mr_inflight && (cyc >= mr_active_from);
                if (in_gap && stop) begin
                    mr_fin = 1; mr_done_at = cyc + 1;
                end else begin
                    if (stop) mr_stop = 1;
                    if (exp_start) begin
                        mr_inflight = 1; mr_active_from = cyc + 1; mr_wd_ref = cyc;
                    end
                    if (active && fire) begin
                        mr_count = mr_count + 16'd1;
                        if (((mr_num != 0) && (mr_count == mr_num)) || mr_stop || stop) begin
                            mr_fin = 1; mr_done_at = cyc + 1;
                        end else begin
                            mr_inflight = 0; mr_start_at = cyc + 1 + mr_gap;
                        end
                    end else if (active) begin
                        if (beat) mr_wd_ref = cyc;
`ifdef AXIS_SEQ_WATCHDOG_EN
                        else if ((mr_tmo != 0) && (cyc - mr_wd_ref >= mr_tmo)) begin
                            mr_fin = 1; mr_done_at = cyc + 1; mr_wd = 1;
                        end
`endif
                    end
                end
            end
        end
        cyc++;
    end

    task automatic bfm_reset();
        bfm_active = 0; bfm_idx = 0; force_cnt = 0;
        m_tvalid = 0; m_tlast = 0; m_busy = 0;
    endtask

    // Master model: one beat per accepted handshake, idle again after TLAST.
    task automatic step();
        @(posedge ACLK);
        #1;
        if (force_cnt > 0) force_cnt--;
        if (samp_fire) begin
            bfm_active = 0; m_tvalid = 0; m_tlast = 0;
        end else if (samp_beat) begin
            bfm_idx++;
            m_tlast = (bfm_idx == bfm_len - 1);
        end
        if (samp_start) begin
            bfm_active = 1; bfm_idx = 0; m_tvalid = 1; m_tlast = (bfm_len == 1);
        end
        m_busy = bfm_active || (force_cnt > 0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_evt(input int which, input int n, input int budget, input string name);
        int k = 0;
        while (((which == 0) ? starts.size() : (which == 1) ? fires.size() : dones.size()) < n
               && k < budget) begin
            step();
            k++;
        end
        check(name, (k < budget), 1'b1);
    endtask

    task automatic start_run(input int num, input int gap, input int tmo, input bit with_stop,
                             output int run_cyc);
        starts.delete(); fires.delete(); dones.delete();
        cfg_num_packets = 16'(num); cfg_gap = 16'(gap); cfg_timeout = 20'(tmo);
        run = 1; stop = with_stop; run_cyc = cyc;
        step();
        run = 0; stop = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int rc;
        int stop_cyc;

        // Reset state.
        #1 ARESET = 1;
        #1;
        check("rst_m_start", m_start, 0);
        check("rst_seq_busy", seq_busy, 0);
        check("rst_seq_done", seq_done, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_wd_timeout", wd_timeout, 0);
        @(posedge ACLK); @(posedge ACLK); #3 ARESET = 0;
        steps(2);

        // num=3, gap=0, 16-beat packets; mid-run run pulse and cfg change ignored.
        bfm_len = 16; m_tready = 1;
        start_run(3, 0, 0, 0, rc);
        cfg_num_packets = 16'd1;
        wait_evt(0, 1, 20, "t1_first_start");
        run = 1; step(); run = 0;
        wait_evt(2, 1, 200, "t1_done");
        check("t1_start_count", starts.size(), 3);
        check("t1_start0_lat", ev(0, 0) - rc, 1);
        check("t1_start1_after_fire0", ev(0, 1) - ev(1, 0), 1);
        check("t1_start2_after_fire1", ev(0, 2) - ev(1, 1), 1);
        check("t1_start_spacing", ev(0, 1) - ev(0, 0), 17);
        check("t1_done_after_fire2", ev(2, 0) - ev(1, 2), 1);
        check("t1_pkt_count", pkt_count, 3);
        steps(3);

        // num=2, gap=5; run and stop in the same IDLE cycle: stop ignored.
        bfm_len = 4;
        start_run(2, 5, 0, 1, rc);
        wait_evt(2, 1, 100, "t2_done");
        check("t2_start_count", starts.size(), 2);
        check("t2_gap_latency", ev(0, 1) - ev(1, 0), 6);
        check("t2_done_after_fire1", ev(2, 0) - ev(1, 1), 1);
        check("t2_busy_after_done", seq_busy, 0);
        check("t2_pkt_count", pkt_count, 2);
        steps(3);

        // Continuous mode, gap=2, stop mid packet 4.
        start_run(0, 2, 0, 0, rc);
        wait_evt(0, 4, 100, "t3_fourth_start");
        step();
        stop = 1; step(); stop = 0;
        wait_evt(2, 1, 50, "t3_done");
        steps(20);
        check("t3_start_count", starts.size(), 4);
        check("t3_pkt_count", pkt_count, 4);
        check("t3_done_after_fire3", ev(2, 0) - ev(1, 3), 1);

        // Stop during GAP after packet 1 of 10.
        start_run(10, 8, 0, 0, rc);
        wait_evt(1, 1, 50, "t4_first_fire");
        step();
        stop = 1; stop_cyc = cyc; step(); stop = 0;
        wait_evt(2, 1, 20, "t4_done");
        steps(15);
        check("t4_finish_latency", ev(2, 0) - stop_cyc, 1);
        check("t4_pkt_count", pkt_count, 1);
        check("t4_start_count", starts.size(), 1);

        // Master busy for 7 cycles on entering ISSUE.
        force_cnt = 8;
        start_run(1, 0, 0, 0, rc);
        wait_evt(2, 1, 60, "t5_done");
        check("t5_start_withheld", ev(0, 0) - rc, 8);
        check("t5_start_count", starts.size(), 1);
        steps(3);

`ifdef AXIS_SEQ_WATCHDOG_EN
        // Stalled slave: watchdog aborts the packet 50 cycles into ACTIVE.
        m_tready = 0;
        start_run(1, 0, 50, 0, rc);
        wait_evt(2, 1, 200, "t6_done");
        check("t6_wd_latency", ev(2, 0) - (ev(0, 0) + 1), 50);
        check("t6_wd_flag", wd_timeout, 1);
        check("t6_pkt_count", pkt_count, 0);
        // Master drains its packet while IDLE: that TLAST must not count.
        m_tready = 1;
        steps(10);
        check("t6_idle_fire_ignored", pkt_count, 0);
`else
        // Watchdog absent: a long stall with a short timeout must not abort.
        m_tready = 0;
        start_run(1, 0, 3, 0, rc);
        steps(12);
        m_tready = 1;
        wait_evt(2, 1, 30, "t6_done");
        check("t6_wd_flag", wd_timeout, 0);
        check("t6_pkt_count", pkt_count, 1);
`endif
        steps(3);

        // Asynchronous reset in the middle of GAP.
        bfm_reset();
        start_run(5, 20, 0, 0, rc);
        wait_evt(1, 1, 50, "t7_first_fire");
        steps(3);
        check("t7_pre_reset_count", pkt_count, 1);
        #2 ARESET = 1;
        bfm_reset();
        #1;
        check("t7_m_start", m_start, 0);
        check("t7_seq_busy", seq_busy, 0);
        check("t7_seq_done", seq_done, 0);
        check("t7_pkt_count", pkt_count, 0);
        check("t7_wd_timeout", wd_timeout, 0);
        steps(2);
        #2 ARESET = 0;
        starts.delete();
        steps(25);
        check("t7_no_start_after_reset", starts.size(), 0);

        // Recovery run after reset.
        start_run(1, 0, 0, 0, rc);
        wait_evt(2, 1, 40, "t8_done");
        check("t8_pkt_count", pkt_count, 1);
        steps(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
